// File: rtl/ifa_arb_pkg.sv
// Shared types and defaults for the ifa bus arbiter: FSM state encoding,
// default watchdog limit and the round-robin index helper.
package ifa_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } arb_state_t;

    localparam int IFA_ARB_TIMEOUT = 16;

    // Index reached by stepping 'step' places past 'base' on a ring of n requesters.
    function automatic int rr_wrap(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/ifa_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit searching
// upward from (last+1) mod NREQ, with wrap.
module rr_pick
    import ifa_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         pick,
    output logic [$clog2(NREQ)-1:0] pick_idx,
    output logic                    pick_valid
);

    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1'b1);

    logic [IW-1:0] cand_idx_s;
    logic          hit_s;

    // Scan from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        cand_idx_s = '0;
        hit_s      = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            cand_idx_s = IW'(rr_wrap(int'(last), i, NREQ));
            hit_s      = req[cand_idx_s];
            pick       = hit_s ? (ONE_HOT0 << cand_idx_s) : pick;
            pick_idx   = hit_s ? cand_idx_s : pick_idx;
            pick_valid = pick_valid | hit_s;
        end
    end

endmodule

// File: rtl/ifa_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for the shared ifa bus:
// grant, start strobe, wait for rdy with watchdog abort, release.
module ifa_bus_arbiter
    import ifa_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = IFA_ARB_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic                    rdy,
    output logic [NREQ-1:0]         gnt,
    output logic                    start,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    arb_state_t       state_r;
    logic [IW-1:0]    last_r;
    logic [CW-1:0]    cnt_r;
    logic [NREQ-1:0]  gnt_r;
    logic             start_r;
    logic [IW-1:0]    owner_r;
    logic             busy_r;
    logic             terr_r;

    logic [NREQ-1:0]  pick_s;
    logic [IW-1:0]    pick_idx_s;
    logic             pick_valid_s;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req        (req),
        .last       (last_r),
        .pick       (pick_s),
        .pick_idx   (pick_idx_s),
        .pick_valid (pick_valid_s)
    );

    // Transaction FSM with watchdog counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            last_r  <= LAST_RST;
            cnt_r   <= '0;
            gnt_r   <= '0;
            start_r <= 1'b0;
            owner_r <= '0;
            busy_r  <= 1'b0;
            terr_r  <= 1'b0;
        end else begin
            start_r <= 1'b0;
            terr_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        gnt_r   <= pick_s;
                        owner_r <= pick_idx_s;
                        busy_r  <= 1'b1;
                        state_r <= GRANT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    // A requester that lets go before start forfeits its turn without moving 'last'.
                    if (req[owner_r]) begin
                        start_r <= 1'b1;
                        state_r <= START;
                    end else begin
                        gnt_r   <= '0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                START: begin
                    cnt_r   <= '0;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (rdy) begin
                        state_r <= DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        terr_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
                        state_r <= WAIT;
                    end
                end
                DONE: begin
                    gnt_r   <= '0;
                    busy_r  <= 1'b0;
                    last_r  <= owner_r;
                    state_r <= IDLE;
                end
                default: begin
                    gnt_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign gnt         = gnt_r;
    assign start       = start_r;
    assign owner       = owner_r;
    assign busy        = busy_r;
    assign timeout_err = terr_r;

endmodule
